// File: rtl/bch_stream_decoder.sv
// Handshaked t=2 binary BCH decoder over GF(2^M): Horner syndromes, division-free
// key equation and a sequential Chien search, one word in flight at a time.
module bch_stream_decoder #(
  parameter int M = 4,
  parameter logic [M:0] PRIM_POLY = 5'b10011,
  localparam int N = (1 << M) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [N-1:0] out_err_vec,
  output logic [1:0]   out_err_cnt,
  output logic         out_uncorr,
  output logic [M-1:0] out_syn1,
  output logic [M-1:0] out_syn3
);

  localparam logic [M-1:0] LAST = M'(N - 1);

  typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   rword_reg;
  logic [N-1:0]   err_vec_reg;
  logic [M-1:0]   s1_reg, s3_reg;
  logic [M-1:0]   t1_reg, t2_reg;
  logic [M-1:0]   j_reg, i_reg;
  logic [1:0]     roots_reg, expected_reg;
  logic           uncorr_flag_reg;

  logic [M-1:0]   s1_sq, s1_cu, sigma2, chien_sum;
  logic [N-1:0]   corrected;
  logic           accept;

  function automatic logic [M-1:0] mul_a(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  function automatic logic [M-1:0] mul_a3(input logic [M-1:0] x);
    return mul_a(mul_a(mul_a(x)));
  endfunction

  // Multiplying by alpha^-1: fold in the polynomial when bit 0 is set, then shift down.
  function automatic logic [M-1:0] div_a(input logic [M-1:0] x);
    logic [M:0] t;
    t = {1'b0, x} ^ (x[0] ? PRIM_POLY : '0);
    return t[M:1];
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int k = M - 1; k >= 0; k--) begin
      p = mul_a(p) ^ (b[k] ? a : '0);
    end
    return p;
  endfunction

  assign s1_sq     = gf_mul(s1_reg, s1_reg);
  assign s1_cu     = gf_mul(s1_sq, s1_reg);
  assign sigma2    = s3_reg ^ s1_cu;
  assign chien_sum = s1_reg ^ t1_reg ^ t2_reg;
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign accept    = in_valid && in_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_correct
    assign corrected[gi] = rword_reg[gi] ^ err_vec_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SYND;
      SYND:    if (j_reg == '0) state_next = KEY;
      KEY:     state_next = (s1_reg == '0) ? DONE : CHIEN;
      CHIEN:   if (i_reg == LAST) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rword_reg       <= '0;
      err_vec_reg     <= '0;
      s1_reg          <= '0;
      s3_reg          <= '0;
      t1_reg          <= '0;
      t2_reg          <= '0;
      j_reg           <= '0;
      i_reg           <= '0;
      roots_reg       <= '0;
      expected_reg    <= '0;
      uncorr_flag_reg <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_err_vec     <= '0;
      out_err_cnt     <= '0;
      out_uncorr      <= 1'b0;
      out_syn1        <= '0;
      out_syn3        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rword_reg       <= in_data;
            s1_reg          <= '0;
            s3_reg          <= '0;
            j_reg           <= LAST;
            err_vec_reg     <= '0;
            roots_reg       <= '0;
            expected_reg    <= '0;
            uncorr_flag_reg <= 1'b0;
          end
        end
        SYND: begin
          s1_reg <= mul_a(s1_reg) ^ {{(M-1){1'b0}}, rword_reg[j_reg]};
          s3_reg <= mul_a3(s3_reg) ^ {{(M-1){1'b0}}, rword_reg[j_reg]};
          j_reg  <= j_reg - 1'b1;
        end
        KEY: begin
          t1_reg          <= s1_sq;
          t2_reg          <= sigma2;
          i_reg           <= '0;
          uncorr_flag_reg <= (s1_reg == '0) && (s3_reg != '0);
          if (s1_reg == '0)       expected_reg <= 2'd0;
          else if (sigma2 == '0)  expected_reg <= 2'd1;
          else                    expected_reg <= 2'd2;
        end
        CHIEN: begin
          // Locator evaluated at alpha^-i; a zero marks an error at position i.
          if (chien_sum == '0) begin
            err_vec_reg[i_reg] <= 1'b1;
            roots_reg          <= roots_reg + 2'd1;
          end
          t1_reg <= div_a(t1_reg);
          t2_reg <= div_a(div_a(t2_reg));
          i_reg  <= i_reg + 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_syn1  <= s1_reg;
            out_syn3  <= s3_reg;
            if (!uncorr_flag_reg && (roots_reg == expected_reg)) begin
              out_data    <= corrected;
              out_err_vec <= err_vec_reg;
              out_err_cnt <= expected_reg;
              out_uncorr  <= 1'b0;
            end else begin
              out_data    <= rword_reg;
              out_err_vec <= '0;
              out_err_cnt <= '0;
              out_uncorr  <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_stream_decoder.sv
// Scoreboard bench for bch_stream_decoder (M=4 and M=5 instances) against a
// brute-force nearest-codeword model built from GF power tables.
module tb_bch_stream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst4 = 1'b1, in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic [14:0] in_data4 = '0;
  logic        in_ready4, out_valid4, out_uncorr4;
  logic [14:0] out_data4, out_err_vec4;
  logic [1:0]  out_err_cnt4;
  logic [3:0]  out_syn1_4, out_syn3_4;

  logic        rst5 = 1'b1, in_valid5 = 1'b0, out_ready5 = 1'b1;
  logic [30:0] in_data5 = '0;
  logic        in_ready5, out_valid5, out_uncorr5;
  logic [30:0] out_data5, out_err_vec5;
  logic [1:0]  out_err_cnt5;
  logic [4:0]  out_syn1_5, out_syn3_5;

  bch_stream_decoder #(.M(4), .PRIM_POLY(5'b10011)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_err_vec(out_err_vec4), .out_err_cnt(out_err_cnt4), .out_uncorr(out_uncorr4),
    .out_syn1(out_syn1_4), .out_syn3(out_syn3_4)
  );

  bch_stream_decoder #(.M(5), .PRIM_POLY(6'b100101)) dut5 (
    .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_err_vec(out_err_vec5), .out_err_cnt(out_err_cnt5), .out_uncorr(out_uncorr5),
    .out_syn1(out_syn1_5), .out_syn3(out_syn3_5)
  );

  typedef struct packed {
    logic [30:0] data;
    logic [30:0] ev;
    logic [1:0]  cnt;
    logic        uncorr;
    logic [4:0]  s1;
    logic [4:0]  s3;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  int   stall_req4 = 0;
  int   g4, g5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int mulx(int m, int poly, int x);
    int v;
    v = x << 1;
    if (((v >> m) & 1) != 0) v = v ^ poly;
    return v;
  endfunction

  function automatic int apow(int m, int poly, int k);
    int v;
    v = 1;
    for (int n = 0; n < k; n++) v = mulx(m, poly, v);
    return v;
  endfunction

  function automatic void syndromes(int m, int poly, logic [30:0] r, output int s1, output int s3);
    int n;
    n = (1 << m) - 1;
    s1 = 0;
    s3 = 0;
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        s1 = s1 ^ apow(m, poly, i);
        s3 = s3 ^ apow(m, poly, (3 * i) % n);
      end
    end
  endfunction

  // The unique error pattern of weight <= 2 with the received syndromes, if any.
  function automatic exp_t model(int m, int poly, logic [30:0] r);
    exp_t e;
    int   n, s1, s3;
    int   p1[31];
    int   p3[31];
    bit   found;
    n = (1 << m) - 1;
    syndromes(m, poly, r, s1, s3);
    e = '0;
    e.data = r;
    e.s1 = s1[4:0];
    e.s3 = s3[4:0];
    e.lat = (s1 == 0) ? n + 2 : 2 * n + 2;
    if (s1 == 0 && s3 == 0) return e;
    for (int i = 0; i < n; i++) begin
      p1[i] = apow(m, poly, i);
      p3[i] = apow(m, poly, (3 * i) % n);
    end
    found = 0;
    for (int i = 0; i < n; i++) begin
      if (p1[i] == s1 && p3[i] == s3) begin
        e.ev[i] = 1'b1;
        e.cnt = 2'd1;
        found = 1;
      end
    end
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (!found && (p1[i] ^ p1[j]) == s1 && (p3[i] ^ p3[j]) == s3) begin
          e.ev[i] = 1'b1;
          e.ev[j] = 1'b1;
          e.cnt = 2'd2;
          found = 1;
        end
      end
    end
    if (found) e.data = r ^ e.ev;
    else e.uncorr = 1'b1;
    return e;
  endfunction

  function automatic int find_gen(int m, int poly);
    int s1, s3, cand;
    logic [30:0] c;
    for (int lo = 1; lo < (1 << (2 * m)); lo += 2) begin
      cand = (1 << (2 * m)) | lo;
      c = cand[30:0];
      syndromes(m, poly, c, s1, s3);
      if (s1 == 0 && s3 == 0) return cand;
    end
    return 0;
  endfunction

  function automatic logic [30:0] rand_cw(int m, int g);
    logic [30:0] c, gv;
    int n;
    n = (1 << m) - 1;
    gv = g[30:0];
    c = '0;
    for (int s = 0; s < n - 2 * m; s++) begin
      if ($urandom_range(1, 0) == 1) c = c ^ (gv << s);
    end
    return c;
  endfunction

  function automatic logic [30:0] add_err(logic [30:0] c, int w, int n);
    logic [30:0] e;
    e = '0;
    while ($countones(e) < w) e[$urandom_range(n - 1, 0)] = 1'b1;
    return c ^ e;
  endfunction

  // ---------------- drivers (called at a negedge) ----------------
  task automatic send4(input logic [14:0] d, input bit push);
    exp_t e;
    int   k;
    e = model(4, 'h13, {16'b0, d});
    in_valid4 = 1'b1;
    in_data4 = d;
    for (k = 0; k < 400; k++) begin
      if (in_ready4) break;
      @(negedge clk);
    end
    if (k == 400) fail_now("send4_timeout");
    else begin
      e.acc = cyc + 1;
      if (push) q4.push_back(e);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic send5(input logic [30:0] d);
    exp_t e;
    int   k;
    e = model(5, 'h25, d);
    in_valid5 = 1'b1;
    in_data5 = d;
    for (k = 0; k < 400; k++) begin
      if (in_ready5) break;
      @(negedge clk);
    end
    if (k == 400) fail_now("send5_timeout");
    else begin
      e.acc = cyc + 1;
      q5.push_back(e);
    end
    @(negedge clk);
    in_valid5 = 1'b0;
  endtask

  // ---------------- monitors ----------------
  initial begin : mon4
    bit          seen;
    int          served;
    exp_t        e;
    logic [14:0] sdata;
    logic [25:0] snap;
    seen = 0;
    served = 0;
    forever begin
      @(negedge clk);
      if (out_valid4 === 1'b1 && !seen) begin
        seen = 1;
        if (served < stall_req4) out_ready4 = 1'b0;
        if (q4.size() == 0) fail_now("unexpected_valid4");
        else begin
          e = q4.pop_front();
          $display("m4 word %h: data %h ev %h cnt %0d unc %0b lat %0d", in_data4, out_data4,
                   out_err_vec4, out_err_cnt4, out_uncorr4, cyc - e.acc);
          chk("data4", out_data4, e.data[14:0]);
          chk("err_vec4", out_err_vec4, e.ev[14:0]);
          chk("err_cnt4", out_err_cnt4, e.cnt);
          chk("uncorr4", out_uncorr4, e.uncorr);
          chk("syn1_4", out_syn1_4, e.s1[3:0]);
          chk("syn3_4", out_syn3_4, e.s3[3:0]);
          chk("latency4", cyc - e.acc, e.lat);
        end
        if (!out_ready4) begin
          sdata = out_data4;
          snap = {out_err_vec4, out_err_cnt4, out_uncorr4, out_syn1_4, out_syn3_4};
          repeat (10) begin
            @(negedge clk);
            chk("stall_data4", out_data4, sdata);
            chk("stall_misc4", {out_err_vec4, out_err_cnt4, out_uncorr4, out_syn1_4, out_syn3_4}, snap);
            chk("stall_valid4", out_valid4, 1);
            chk("stall_in_ready4", in_ready4, 0);
          end
          served++;
          out_ready4 = 1'b1;
        end
      end else if (out_valid4 === 1'b0 && seen) begin
        seen = 0;
        chk("in_ready_after_hs4", in_ready4, 1);
      end
    end
  end

  initial begin : mon5
    bit   seen;
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (out_valid5 === 1'b1 && !seen) begin
        seen = 1;
        if (q5.size() == 0) fail_now("unexpected_valid5");
        else begin
          e = q5.pop_front();
          $display("m5 word %h: data %h ev %h cnt %0d unc %0b lat %0d", in_data5, out_data5,
                   out_err_vec5, out_err_cnt5, out_uncorr5, cyc - e.acc);
          chk("data5", out_data5, e.data);
          chk("err_vec5", out_err_vec5, e.ev);
          chk("err_cnt5", out_err_cnt5, e.cnt);
          chk("uncorr5", out_uncorr5, e.uncorr);
          chk("syn1_5", out_syn1_5, e.s1);
          chk("syn3_5", out_syn3_5, e.s3);
          chk("latency5", cyc - e.acc, e.lat);
        end
      end else if (out_valid5 === 1'b0 && seen) begin
        seen = 0;
        chk("in_ready_after_hs5", in_ready5, 1);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    exp_t        e;
    logic [30:0] w;
    g4 = find_gen(4, 'h13);
    g5 = find_gen(5, 'h25);

    e = model(4, 'h13, 31'h01F1);
    chk("ref_01F1_data", e.data, 31'h01D1);
    chk("ref_01F1_ev", e.ev, 31'h0020);
    e = model(4, 'h13, 31'h4001);
    chk("ref_4001_cnt", e.cnt, 2);

    repeat (3) @(negedge clk);
    chk("rst_in_ready4", in_ready4, 0);
    chk("rst_out4", {out_valid4, out_data4, out_err_vec4, out_err_cnt4, out_uncorr4, out_syn1_4, out_syn3_4}, 0);
    chk("rst_out5", {out_valid5, out_data5, out_err_vec5, out_err_cnt5, out_uncorr5, out_syn1_5, out_syn3_5}, 0);
    rst4 = 1'b0;
    rst5 = 1'b0;
    #1;
    chk("rst_release_in_ready4", in_ready4, 1);
    chk("rst_release_in_ready5", in_ready5, 1);
    @(negedge clk);

    fork
      begin
        send4(15'h0000, 1);
        send4(15'h01F1, 1);
        send4(15'h4001, 1);
        for (int n = 0; n < 24; n++) begin
          w = add_err(rand_cw(4, g4), $urandom_range(4, 0), 15);
          send4(w[14:0], 1);
        end
        stall_req4++;
        w = add_err(rand_cw(4, g4), 1, 15);
        send4(w[14:0], 1);
        w = add_err(rand_cw(4, g4), 2, 15);
        send4(w[14:0], 1);
        // Abort a word mid-CHIEN, then confirm the next word decodes normally.
        w = add_err(rand_cw(4, g4), 1, 15);
        send4(w[14:0], 0);
        repeat (20) @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("mid_rst_in_ready4", in_ready4, 0);
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        chk("post_rst_in_ready4", in_ready4, 1);
        chk("post_rst_out4", {out_valid4, out_data4, out_err_vec4, out_err_cnt4, out_uncorr4, out_syn1_4, out_syn3_4}, 0);
        @(negedge clk);
        repeat (40) @(negedge clk);
        chk("post_rst_quiet4", out_valid4, 0);
        w = add_err(rand_cw(4, g4), 2, 15);
        send4(w[14:0], 1);
        w = add_err(rand_cw(4, g4), 3, 15);
        send4(w[14:0], 1);
      end
      begin
        send5(31'h40000000);
        for (int n = 0; n < 5; n++) begin
          send5(add_err(rand_cw(5, g5), n % 4, 31));
        end
      end
    join

    for (int k = 0; k < 3000 && (q4.size() != 0 || q5.size() != 0); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    while (q4.size() != 0) begin
      void'(q4.pop_front());
      fail_now("missing_output4");
    end
    while (q5.size() != 0) begin
      void'(q5.pop_front());
      fail_now("missing_output5");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
